// File: rtl/sprite_anim.sv
`default_nettype none
// ============================================================================
// Module   : sprite_anim
// Purpose  : Animated-sprite engine. It maps the pixel coordinate onto a
//            multi-frame sprite sheet in an external registered ROM, decodes
//            the colour index through a loadable palette, and steps the
//            animation frame on a vertical-frame cadence (loop or ping-pong).
// Revision : 1.0 - initial release
// ============================================================================
module sprite_anim #(
  parameter int W           = 64,
  parameter int H           = 64,
  parameter int FRAMES      = 4,
  parameter int FRAME_TICKS = 6,
  parameter int CW          = 3,
  parameter int TRANSP      = 0,
  parameter int AW          = $clog2(FRAMES * W * H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_start,
  input  logic [9:0]    pixelx,
  input  logic [9:0]    pixely,
  input  logic [9:0]    posx,
  input  logic [9:0]    posy,
  input  logic          mirror,
  input  logic          anim_en,
  input  logic          anim_mode,
  output logic [AW-1:0] rom_addr,
  input  logic [CW-1:0] rom_data,
  input  logic          pal_we,
  input  logic [CW-1:0] pal_idx,
  input  logic [23:0]   pal_rgb,
  output logic [23:0]   RGB,
  output logic          visible
);

  localparam int FW   = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int TW   = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam int NPAL = 1 << CW;

  // Per-video-frame shadow copies of the request inputs
  logic [9:0] sh_posx;
  logic [9:0] sh_posy;
  logic       sh_mirror;
  logic       sh_en;
  logic       sh_mode;

  // Animation state
  logic [TW-1:0] tick;
  logic [FW-1:0] frame;
  logic          dir_down;
  logic [FW-1:0] next_frame;
  logic          next_dir;
  logic          step_mode;

  // Pipeline
  logic          inbox_s1;
  logic          inbox_s2;
  logic [23:0]   palette [NPAL];

  // Geometry, widened to 11 bits so a box straddling x=1023 does not wrap
  logic [10:0]   px11, py11, sx11, sy11;
  logic [10:0]   dx, dy, col;
  logic          inbox;
  logic [AW-1:0] addr_next;
  logic          opaque;

  assign px11  = {1'b0, pixelx};
  assign py11  = {1'b0, pixely};
  assign sx11  = {1'b0, sh_posx};
  assign sy11  = {1'b0, sh_posy};
  assign inbox = (px11 >= sx11) && (px11 < sx11 + 11'(W)) &&
                 (py11 >= sy11) && (py11 < sy11 + 11'(H));
  assign dx    = px11 - sx11;
  assign dy    = py11 - sy11;
  assign col   = sh_mirror ? (11'(W - 1) - dx) : dx;
  assign addr_next = inbox ? (AW'(frame) * AW'(W * H) + AW'(dy) * AW'(W) + AW'(col))
                           : '0;
  assign opaque = inbox_s2 && (rom_data != CW'(TRANSP));

  // The step taken at a frame_start uses the mode being sampled on that pulse
  assign step_mode = frame_start ? anim_mode : sh_mode;

  // Next frame index and direction for one animation step
  always_comb begin
    next_frame = frame;
    next_dir   = dir_down;
    if (FRAMES > 1) begin
      if (!step_mode) begin
        next_frame = (frame == FW'(FRAMES - 1)) ? '0 : frame + 1'b1;
      end else if (!dir_down) begin
        if (frame == FW'(FRAMES - 1)) begin
          // Reached the top while moving up (possible after a loop-mode wrap)
          next_frame = frame - 1'b1;
          next_dir   = 1'b1;
        end else begin
          next_frame = frame + 1'b1;
          if (frame + 1'b1 == FW'(FRAMES - 1)) next_dir = 1'b1;
        end
      end else begin
        if (frame == '0) begin
          next_frame = frame + 1'b1;
          next_dir   = 1'b0;
        end else begin
          next_frame = frame - 1'b1;
          if (frame == FW'(1)) next_dir = 1'b0;
        end
      end
    end
  end

  // Latch request inputs at the start of vertical blanking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_posx   <= '0;
      sh_posy   <= '0;
      sh_mirror <= 1'b0;
      sh_en     <= 1'b0;
      sh_mode   <= 1'b0;
    end else if (frame_start) begin
      sh_posx   <= posx;
      sh_posy   <= posy;
      sh_mirror <= mirror;
      sh_en     <= anim_en;
      sh_mode   <= anim_mode;
    end
  end

  // Advance tick/frame on frame_start when the previously latched enable is set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick     <= '0;
      frame    <= '0;
      dir_down <= 1'b0;
    end else if (frame_start && sh_en) begin
      if (tick == TW'(FRAME_TICKS - 1)) begin
        tick     <= '0;
        frame    <= next_frame;
        dir_down <= next_dir;
      end else begin
        tick <= tick + 1'b1;
      end
    end
  end

  // Palette register file; a same-cycle lookup sees the pre-write value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NPAL; i++) palette[i] <= '0;
    end else if (pal_we) begin
      palette[pal_idx] <= pal_rgb;
    end
  end

  // Three-stage pixel pipeline: address, ROM wait, colour decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr <= '0;
      inbox_s1 <= 1'b0;
      inbox_s2 <= 1'b0;
      visible  <= 1'b0;
      RGB      <= '0;
    end else begin
      rom_addr <= addr_next;
      inbox_s1 <= inbox;
      inbox_s2 <= inbox_s1;
      visible  <= opaque;
      RGB      <= opaque ? palette[rom_data] : 24'h000000;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sprite_anim.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_anim
// Purpose  : Directed self-checking bench for sprite_anim (default params).
//            ROM model: registered, data = addr[2:0] ^ 3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_anim;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_start = 1'b0;
  logic [9:0]  pixelx = 10'd1023;
  logic [9:0]  pixely = 10'd1023;
  logic [9:0]  posx = '0;
  logic [9:0]  posy = '0;
  logic        mirror = 1'b0;
  logic        anim_en = 1'b0;
  logic        anim_mode = 1'b0;
  logic [13:0] rom_addr;
  logic [2:0]  rom_data = '0;
  logic        pal_we = 1'b0;
  logic [2:0]  pal_idx = '0;
  logic [23:0] pal_rgb = '0;
  logic [23:0] RGB;
  logic        visible;

  int assertions = 0;
  int failures   = 0;
  int pp_frames [6] = '{2, 3, 2, 1, 0, 1};

  sprite_anim dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .pixelx(pixelx), .pixely(pixely), .posx(posx), .posy(posy),
    .mirror(mirror), .anim_en(anim_en), .anim_mode(anim_mode),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .pal_we(pal_we), .pal_idx(pal_idx), .pal_rgb(pal_rgb),
    .RGB(RGB), .visible(visible)
  );

  always #5 clk = ~clk;

  // Registered sprite-sheet ROM model
  always @(posedge clk) rom_data <= rom_addr[2:0] ^ 3'd3;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertions++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [9:0] x, input logic [9:0] y,
                       input logic m, input logic e, input logic md);
    posx = x; posy = y; mirror = m; anim_en = e; anim_mode = md;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic pal_write(input logic [2:0] idx, input logic [23:0] rgb);
    pal_we = 1'b1; pal_idx = idx; pal_rgb = rgb;
    step();
    pal_we = 1'b0;
  endtask

  // Present one pixel, then check address (1 cycle) and colour (3 cycles)
  task automatic probe(input string tag, input logic [9:0] x, input logic [9:0] y,
                       input logic [31:0] ea, input logic ev, input logic [23:0] ergb);
    pixelx = x; pixely = y;
    step();
    chk({tag, ".addr"}, 32'(rom_addr), ea);
    pixelx = 10'd1023; pixely = 10'd1023;
    step();
    chk({tag, ".early"}, 32'(visible), 32'd0);
    step();
    chk({tag, ".vis"}, 32'(visible), 32'(ev));
    chk({tag, ".rgb"}, 32'(RGB), 32'(ergb));
  endtask

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) step();
    chk("reset.addr", 32'(rom_addr), 32'd0);
    chk("reset.vis", 32'(visible), 32'd0);
    chk("reset.rgb", 32'(RGB), 32'd0);
    rst_n = 1'b1;
    step();

    pal_write(3'd3, 24'hFF0000);
    pal_write(3'd2, 24'h00FF00);
    pal_write(3'd4, 24'h0000FF);

    // Position, latency and box boundaries
    pulse(10'd100, 10'd50, 1'b0, 1'b0, 1'b0);
    probe("pos",    10'd100, 10'd50,  0,    1'b1, 24'hFF0000);
    probe("pos2",   10'd101, 10'd51,  65,   1'b1, 24'h00FF00);
    probe("left",   10'd99,  10'd50,  0,    1'b0, 24'h000000);
    probe("right",  10'd164, 10'd50,  0,    1'b0, 24'h000000);
    probe("corner", 10'd163, 10'd113, 4095, 1'b1, 24'h0000FF);
    probe("below",  10'd100, 10'd114, 0,    1'b0, 24'h000000);
    probe("transp", 10'd103, 10'd50,  3,    1'b0, 24'h000000);

    // Mirror latched only on frame_start
    pulse(10'd100, 10'd50, 1'b1, 1'b0, 1'b0);
    probe("mir0", 10'd100, 10'd50, 63, 1'b1, 24'h0000FF);
    probe("mir1", 10'd163, 10'd50, 0,  1'b1, 24'hFF0000);
    mirror = 1'b0;
    probe("mirhold", 10'd100, 10'd50, 63, 1'b1, 24'h0000FF);

    // Loop animation, 6 ticks per frame
    pulse(10'd100, 10'd50, 1'b0, 1'b1, 1'b0);
    repeat (5) pulse(10'd100, 10'd50, 1'b0, 1'b1, 1'b0);
    probe("loop5", 10'd100, 10'd50, 0, 1'b1, 24'hFF0000);
    pulse(10'd100, 10'd50, 1'b0, 1'b1, 1'b0);
    probe("loop6", 10'd100, 10'd50, 4096, 1'b1, 24'hFF0000);
    repeat (6) pulse(10'd100, 10'd50, 1'b0, 1'b1, 1'b0);
    probe("loop12", 10'd100, 10'd50, 8192, 1'b1, 24'hFF0000);
    repeat (12) pulse(10'd100, 10'd50, 1'b0, 1'b1, 1'b0);
    probe("loop24", 10'd100, 10'd50, 0, 1'b1, 24'hFF0000);

    // Ping-pong: 1,2,3,2,1,0,1
    repeat (6) pulse(10'd100, 10'd50, 1'b0, 1'b1, 1'b1);
    probe("pp1", 10'd100, 10'd50, 4096, 1'b1, 24'hFF0000);
    for (int k = 0; k < 6; k++) begin
      repeat (6) pulse(10'd100, 10'd50, 1'b0, 1'b1, 1'b1);
      probe($sformatf("pp_step%0d", k), 10'd100, 10'd50,
            32'(pp_frames[k] * 4096), 1'b1, 24'hFF0000);
    end

    // Freeze with anim_en=0 (tick now 1, frame 1)
    repeat (13) pulse(10'd100, 10'd50, 1'b0, 1'b0, 1'b1);
    probe("freeze", 10'd100, 10'd50, 4096, 1'b1, 24'hFF0000);

    // Palette write concurrent with a lookup of the same index
    pixelx = 10'd100; pixely = 10'd50;
    step();
    step();
    pixelx = 10'd1023; pixely = 10'd1023;
    pal_we = 1'b1; pal_idx = 3'd3; pal_rgb = 24'h123456;
    step();
    pal_we = 1'b0;
    chk("palwr.old", 32'(RGB), 32'h00FF0000);
    step();
    chk("palwr.new", 32'(RGB), 32'h00123456);

    // Reach frame 2, then async reset mid-line
    pulse(10'd100, 10'd50, 1'b0, 1'b1, 1'b1);
    repeat (5) pulse(10'd100, 10'd50, 1'b0, 1'b1, 1'b1);
    probe("f2", 10'd100, 10'd50, 8192, 1'b1, 24'h123456);
    pixelx = 10'd100; pixely = 10'd50;
    step();
    chk("pre_rst.addr", 32'(rom_addr), 32'd8192);
    step();
    step();
    chk("pre_rst.vis", 32'(visible), 32'd1);
    chk("pre_rst.rgb", 32'(RGB), 32'h00123456);
    #2 rst_n = 1'b0;
    #1;
    chk("async.addr", 32'(rom_addr), 32'd0);
    chk("async.vis", 32'(visible), 32'd0);
    chk("async.rgb", 32'(RGB), 32'd0);
    pixelx = 10'd1023; pixely = 10'd1023;
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst.vis", 32'(visible), 32'd0);
    probe("rst_box", 10'd1,  10'd1, 65, 1'b1, 24'h000000);
    probe("rst_out", 10'd64, 10'd0, 0,  1'b0, 24'h000000);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
`default_nettype wire
